// File: rtl/pc_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ctrl -- next-PC selection and pipeline hazard control
//
// Chooses the next PC and drives the pipeline write/flush controls. The
// priority from highest to lowest is: reset, exception, stall, jr, jump,
// taken branch, then sequential PC+4.
//
// A stall comes from one of two sources:
//   * load-use: the EX stage holds a load whose destination register
//     (not $0) is read by the instruction in ID;
//   * multiply/divide busy: the ID instruction needs the MD unit while it is
//     still counting (only when the MD feature is built in).
//
// Optional feature: define PC_CTRL_MD_STALL_EN to include the multiply/divide
// busy counter and its stall. Without it, md_busy is tied 0 and md_start,
// md_is_div and id_md_use are ignored.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   PC                         current PC
//   br_taken/jump/jr           ID redirect requests, with *_target addresses
//   id_rs, id_rt               ID source registers
//   id_md_use                  ID instruction uses the MD unit
//   ex_memread, ex_rt          EX-stage load and its destination register
//   md_start, md_is_div        start multiply (0) or divide (1) from EX
//   exc                        exception raised this cycle
//   NPC                        next PC
//   PC_write, IFID_write       enables for the PC and IF/ID registers
//   IFID_flush, IDEX_flush     bubble insertion into IF/ID and ID/EX
//   md_busy                    registered MD unit busy flag
// ---------------------------------------------------------------------------
module pc_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0c00,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
    parameter int          MULT_CYCLES = 5,
    parameter int          DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        br_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] br_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_md_use,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        exc,
    output logic [31:0] NPC,
    output logic        PC_write,
    output logic        IFID_write,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic        md_busy
);

    logic [31:0] pc_plus4;
    logic        load_use;
    logic        md_stall;
    logic        stall;

    assign pc_plus4 = PC + 32'd4;

    // A load into $0 never produces a real value, so it never stalls.
    assign load_use = ex_memread && (ex_rt != 5'd0)
                      && ((ex_rt == id_rs) || (ex_rt == id_rt));

`ifdef PC_CTRL_MD_STALL_EN
    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MD_CW  = (MD_MAX < 1) ? 1 : $clog2(MD_MAX + 1);

    logic [MD_CW-1:0] md_cnt_reg;
    logic [MD_CW-1:0] md_cnt_next;
    logic             md_busy_reg;

    // A start is only accepted while idle; a start during a running count
    // is dropped. Exceptions do not touch the count.
    always_comb begin
        md_cnt_next = md_cnt_reg;
        if (md_cnt_reg != '0) begin
            md_cnt_next = md_cnt_reg - MD_CW'(1);
        end else if (md_start) begin
            md_cnt_next = md_is_div ? MD_CW'(DIV_CYCLES) : MD_CW'(MULT_CYCLES);
        end
    end

    // Busy is registered from the next count so it is high for exactly the
    // N cycles after the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_reg  <= '0;
            md_busy_reg <= 1'b0;
        end else begin
            md_cnt_reg  <= md_cnt_next;
            md_busy_reg <= (md_cnt_next != '0);
        end
    end

    assign md_busy  = md_busy_reg;
    assign md_stall = md_busy_reg && id_md_use;
`else
    logic unused_md_inputs;
    localparam int UNUSED_MD_CYCLES = MULT_CYCLES + DIV_CYCLES;

    assign unused_md_inputs = ^{md_start, md_is_div, id_md_use, clk,
                                UNUSED_MD_CYCLES[0]};
    assign md_busy  = 1'b0;
    assign md_stall = 1'b0;
`endif

    assign stall = load_use || md_stall;

    // A redirect raised during a stall is simply not acted on; the ID
    // instruction is held, so the request is presented again next cycle.
    always_comb begin
        NPC        = pc_plus4;
        PC_write   = 1'b1;
        IFID_write = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        if (rst) begin
            NPC        = RESET_PC;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (exc) begin
            NPC        = EXC_VECTOR;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (stall) begin
            NPC        = PC;
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
        end else if (jr) begin
            NPC        = jr_target;
            IFID_flush = 1'b1;
        end else if (jump) begin
            NPC        = jump_target;
            IFID_flush = 1'b1;
        end else if (br_taken) begin
            NPC        = br_target;
            IFID_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_ctrl -- scoreboard testbench for pc_ctrl
//
// The driver applies one set of inputs per cycle, computes the expected
// outputs from a behavioural model (priority table plus an MD busy window
// tracked as an absolute cycle range) and queues them. A monitor on the
// falling edge pops each expectation and compares it with the DUT.
// Honours PC_CTRL_MD_STALL_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_pc_ctrl;

    localparam logic [31:0] RESET_PC    = 32'h0000_0c00;
    localparam logic [31:0] EXC_VECTOR  = 32'h0000_4180;
    localparam int          MULT_CYCLES = 5;
    localparam int          DIV_CYCLES  = 10;
`ifdef PC_CTRL_MD_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] npc;
        logic        pc_write;
        logic        ifid_write;
        logic        ifid_flush;
        logic        idex_flush;
        logic        md_busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        br_taken, jump, jr;
    logic [31:0] br_target, jump_target, jr_target;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_md_use, ex_memread, md_start, md_is_div, exc;
    logic [31:0] NPC;
    logic        PC_write, IFID_write, IFID_flush, IDEX_flush, md_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_end = -1;     // model: MD unit busy during cycles <= busy_end
    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    pc_ctrl #(
        .RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR),
        .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .PC(PC),
        .br_taken(br_taken), .jump(jump), .jr(jr),
        .br_target(br_target), .jump_target(jump_target), .jr_target(jr_target),
        .id_rs(id_rs), .id_rt(id_rt), .id_md_use(id_md_use),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .md_start(md_start), .md_is_div(md_is_div), .exc(exc),
        .NPC(NPC), .PC_write(PC_write), .IFID_write(IFID_write),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .md_busy(md_busy)
    );

    function automatic exp_t model();
        exp_t e;
        bit   busy_now;
        bit   hazard;
        busy_now = MD_EN && (cyc <= busy_end);
        hazard   = (ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt))
                   || (busy_now && id_md_use);
        e.md_busy = busy_now;
        if (rst)
            {e.npc, e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush} = {RESET_PC, 4'b1111};
        else if (exc)
            {e.npc, e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush} = {EXC_VECTOR, 4'b1111};
        else if (hazard)
            {e.npc, e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush} = {PC, 4'b0001};
        else if (jr)
            {e.npc, e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush} = {jr_target, 4'b1110};
        else if (jump)
            {e.npc, e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush} = {jump_target, 4'b1110};
        else if (br_taken)
            {e.npc, e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush} = {br_target, 4'b1110};
        else
            {e.npc, e.pc_write, e.ifid_write, e.ifid_flush, e.idex_flush} = {PC + 32'd4, 4'b1100};
        return e;
    endfunction

    task automatic clear_in(input logic [31:0] pc_val);
        rst = 1'b0; PC = pc_val;
        br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        br_target = 32'h0000_1000; jump_target = 32'h0000_2000; jr_target = 32'h0000_3000;
        id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
        id_md_use = 1'b0; ex_memread = 1'b0; md_start = 1'b0; md_is_div = 1'b0; exc = 1'b0;
    endtask

    // Queue the expectation for the current inputs, then advance the model
    // across the next rising edge.
    task automatic step(input string nm);
        exp_q.push_back(model());
        name_q.push_back(nm);
        @(posedge clk);
        if (rst)
            busy_end = -1;
        else if (MD_EN && md_start && !(cyc <= busy_end))
            busy_end = cyc + (md_is_div ? DIV_CYCLES : MULT_CYCLES);
        cyc++;
        #1;
    endtask

    // Monitor: one comparison per cycle that has a queued expectation.
    initial begin
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = '{NPC, PC_write, IFID_write, IFID_flush, IDEX_flush, md_busy};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got npc=%h pcw=%b ifw=%b iff=%b idf=%b busy=%b, expected npc=%h pcw=%b ifw=%b iff=%b idf=%b busy=%b",
                             nm, got.npc, got.pc_write, got.ifid_write, got.ifid_flush,
                             got.idex_flush, got.md_busy, e.npc, e.pc_write, e.ifid_write,
                             e.ifid_flush, e.idex_flush, e.md_busy);
                end else begin
                    $display("ok   %s: npc=%h pcw=%b ifw=%b iff=%b idf=%b busy=%b",
                             nm, got.npc, got.pc_write, got.ifid_write, got.ifid_flush,
                             got.idex_flush, got.md_busy);
                end
            end
        end
    end

    initial begin
        // Unchecked warm-up reset so the MD state is defined.
        clear_in(32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset behaviour, then md_busy low the cycle after.
        clear_in(32'h0); rst = 1'b1; step("reset");
        clear_in(32'h0000_0c00); step("after_reset");

        // Load-use stall swallows a branch; ex_rt=0 does not stall.
        clear_in(32'h0000_0c10);
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; br_taken = 1'b1;
        step("load_use_stall");
        ex_rt = 5'd0; id_rt = 5'd0;
        step("load_rt0_branch");
        clear_in(32'h0000_0c20);
        ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9;
        step("load_use_rt");

        // Redirect priority.
        clear_in(32'h0000_0c30);
        jr = 1'b1; jump = 1'b1; br_taken = 1'b1;
        jr_target = 32'h0000_0d00; jump_target = 32'h0000_0e00;
        step("jr_priority");
        jr = 1'b0; step("jump_priority");
        jump = 1'b0; step("branch_only");

        // PC+4 wraps.
        clear_in(32'hFFFF_FFFC); step("pc_wrap");

        // Divide busy window with a second start ignored and an exception
        // during a combined load-use and MD stall.
        clear_in(32'h0000_0c40);
        id_md_use = 1'b1; md_start = 1'b1; md_is_div = 1'b1;
        step("div_start");
        md_start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            md_start   = (i == 3);
            md_is_div  = 1'b0;
            exc        = (i == 5);
            ex_memread = (i == 5);
            ex_rt      = 5'd8; id_rs = 5'd8;
            step($sformatf("div_busy_%0d", i));
        end

        // Multiply window, then reset in the middle of it.
        clear_in(32'h0000_0c50);
        id_md_use = 1'b1; md_start = 1'b1;
        step("mult_start");
        md_start = 1'b0;
        for (int i = 1; i <= 7; i++) step($sformatf("mult_busy_%0d", i));
        md_start = 1'b1; md_is_div = 1'b1; step("div_restart");
        md_start = 1'b0; step("div_run");
        rst = 1'b1; step("reset_mid_md");
        rst = 1'b0; step("after_abort");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(49) == 0);
            exc         = ($urandom_range(15) == 0);
            PC          = {$urandom(), 2'b00} ;
            br_taken    = ($urandom_range(3) == 0);
            jump        = ($urandom_range(3) == 0);
            jr          = ($urandom_range(3) == 0);
            br_target   = $urandom();
            jump_target = $urandom();
            jr_target   = $urandom();
            id_rs       = 5'($urandom_range(3));
            id_rt       = 5'($urandom_range(3));
            ex_rt       = 5'($urandom_range(3));
            ex_memread  = ($urandom_range(2) == 0);
            id_md_use   = ($urandom_range(1) == 0);
            md_start    = ($urandom_range(5) == 0);
            md_is_div   = ($urandom_range(1) == 0);
            step($sformatf("rand_%0d", i));
        end

        clear_in(32'h0);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
